// File: rtl/flash_spi_arb.sv
// Arbitrates one SPI flash between an external host (default owner) and an
// internal command engine issuing opcode/address/write/read frames.
module flash_spi_arb #(
  parameter int G_SCK_DIV = 2,
  parameter int G_GUARD   = 4
) (
  input  logic        p_in_clk,
  input  logic        p_in_rst_n,
  input  logic        p_in_start,
  input  logic [7:0]  p_in_cmd,
  input  logic [23:0] p_in_addr,
  input  logic        p_in_addr_en,
  input  logic [2:0]  p_in_wr_cnt,
  input  logic [31:0] p_in_wr_data,
  input  logic [2:0]  p_in_rd_cnt,
  output logic [31:0] p_out_rd_data,
  output logic        p_out_busy,
  output logic        p_out_done,
  output logic        p_out_err,
  input  logic        p_in_ext_cs_n,
  input  logic        p_in_ext_sck,
  input  logic        p_in_ext_mosi,
  output logic        p_out_ext_miso,
  output logic        p_out_ext_blocked,
  output logic        p_out_flash_cs_n,
  output logic        p_out_flash_sck,
  output logic        p_out_flash_mosi,
  input  logic        p_in_flash_miso
);

  typedef enum logic [2:0] {IDLE, WAIT_EXT, CS_SETUP, SHIFT, CS_HOLD, GUARD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cs_sync;
  logic        ext_cs_s;
  logic [7:0]  cnt_q;
  // worst-case frame is 96 bits, so the bit counters need 7 bits
  logic [6:0]  bit_cnt_q, tx_bits_q, total_q, tx_bits_d;
  logic [63:0] tx_sr_q;
  logic        sck_q;
  logic [31:0] rd_q;
  logic        done_q, err_q, blocked_q;
  logic        start_bad, div_end, owner_int, rise_now, fall_now;
  logic        int_cs_n, int_mosi;

  assign ext_cs_s  = cs_sync[1];
  assign start_bad = p_in_start && (p_in_wr_cnt > 3'd4 || p_in_rd_cnt > 3'd4);
  assign div_end   = (cnt_q == 8'(G_SCK_DIV - 1));
  assign owner_int = state_q inside {CS_SETUP, SHIFT, CS_HOLD, GUARD};
  assign tx_bits_d = 7'd8 + (p_in_addr_en ? 7'd24 : 7'd0) + {1'b0, p_in_wr_cnt, 3'b000};

  // SCK rises at the end of setup and at the end of every low phase except the last
  assign rise_now = (state_q == CS_SETUP && div_end) ||
                    (state_q == SHIFT && div_end && !sck_q && bit_cnt_q != total_q);
  assign fall_now = (state_q == SHIFT) && div_end && sck_q;

  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) cs_sync <= 2'b11;
    else             cs_sync <= {cs_sync[0], p_in_ext_cs_n};
  end

  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (p_in_start && !start_bad) state_d = WAIT_EXT;
      WAIT_EXT: if (ext_cs_s && cnt_q == 8'(G_GUARD - 1)) state_d = CS_SETUP;
      CS_SETUP: if (div_end) state_d = SHIFT;
      SHIFT:    if (div_end && !sck_q && bit_cnt_q == total_q) state_d = CS_HOLD;
      CS_HOLD:  if (div_end) state_d = GUARD;
      GUARD:    if (cnt_q == 8'(G_GUARD - 1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_bits_q <= '0;
      total_q   <= '0;
      tx_sr_q   <= '0;
      sck_q     <= 1'b0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      // one counter serves the ext-quiet window, SCK phases and the guard gap
      if (state_d != state_q || (state_q == WAIT_EXT && !ext_cs_s) ||
          (state_q inside {CS_SETUP, SHIFT, CS_HOLD} && div_end))
        cnt_q <= '0;
      else if (state_q != IDLE)
        cnt_q <= cnt_q + 8'd1;

      err_q  <= (state_q == IDLE) && start_bad;
      done_q <= (state_q == CS_HOLD) && (state_d == GUARD);

      if (state_q == IDLE && p_in_start && !start_bad) begin
        tx_sr_q   <= p_in_addr_en ? {p_in_cmd, p_in_addr, p_in_wr_data}
                                  : {p_in_cmd, p_in_wr_data, 24'h0};
        tx_bits_q <= tx_bits_d;
        total_q   <= tx_bits_d + {1'b0, p_in_rd_cnt, 3'b000};
        bit_cnt_q <= '0;
        rd_q      <= '0;
      end

      if (rise_now) begin
        sck_q <= 1'b1;
        if (bit_cnt_q >= tx_bits_q) rd_q <= {rd_q[30:0], p_in_flash_miso};
      end
      if (fall_now) begin
        sck_q     <= 1'b0;
        tx_sr_q   <= {tx_sr_q[62:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 7'd1;
      end

      if (owner_int && !ext_cs_s)         blocked_q <= 1'b1;
      else if (state_q == IDLE && ext_cs_s) blocked_q <= 1'b0;
    end
  end

  assign int_cs_n = !(state_q inside {CS_SETUP, SHIFT, CS_HOLD});
  assign int_mosi = (bit_cnt_q < tx_bits_q) ? tx_sr_q[63] : 1'b0;

  // reset gates the flash pins so the external path cannot select the part
  assign p_out_flash_cs_n  = !p_in_rst_n || (owner_int ? int_cs_n : p_in_ext_cs_n);
  assign p_out_flash_sck   = p_in_rst_n && (owner_int ? sck_q : p_in_ext_sck);
  assign p_out_flash_mosi  = p_in_rst_n && (owner_int ? int_mosi : p_in_ext_mosi);
  assign p_out_ext_miso    = owner_int ? 1'b1 : p_in_flash_miso;
  assign p_out_ext_blocked = blocked_q;
  assign p_out_busy        = (state_q != IDLE);
  assign p_out_done        = done_q;
  assign p_out_err         = err_q;
  assign p_out_rd_data     = rd_q;

endmodule
